// File: rtl/src_sched_2ph_if.sv
// Bundle between the clocked requesters / async pipeline and the 2-phase source scheduler.
// The scheduler attaches through the slave modport.
interface src_sched_2ph_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned BW_DATA = 8
);
    localparam int unsigned OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*BW_DATA-1:0] data;
    logic [NUM_REQ-1:0]         grant;
    logic [OW-1:0]              owner;
    logic [BW_DATA-1:0]         out_data;
    logic                       out_req;
    logic                       out_ack;
    logic                       busy;
    logic                       timeout;
    logic [15:0]                tok_cnt;

    modport master (
        output req, data, out_ack,
        input  grant, owner, out_data, out_req, busy, timeout, tok_cnt
    );

    modport slave (
        input  req, data, out_ack,
        output grant, owner, out_data, out_req, busy, timeout, tok_cnt
    );
endinterface

// File: rtl/src_sched_2ph.sv
// Round-robin scheduler feeding one 2-phase bundled-data source: capture, hold SETUP_CYC
// cycles, toggle req, then wait for the synchronised ack to match.
module src_sched_2ph #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned BW_DATA   = 8,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned TIMEOUT   = 255
) (
    input logic           clk,
    input logic           rst,
    src_sched_2ph_if.slave bus
);
    localparam int unsigned OW = $clog2(NUM_REQ);
    localparam int unsigned SW = $clog2(SETUP_CYC + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StWait} state_e;

    state_e               state_q;
    logic [OW-1:0]        ptr_q;
    logic [OW-1:0]        owner_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [BW_DATA-1:0]   out_data_q;
    logic                 out_req_q;
    logic                 busy_q;
    logic                 timeout_q;
    logic [15:0]          tok_cnt_q;
    logic [15:0]          wait_cnt_q;
    logic [SW-1:0]        setup_cnt_q;
    logic                 ack_meta;
    logic                 ack_s;

    logic                 win_found;
    logic [OW-1:0]        win_idx;

    // Only these two flops ever sample the asynchronous ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= bus.out_ack;
            ack_s    <= ack_meta;
        end
    end

    // Search order ptr+1, ptr+2, ... so the last winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % int'(NUM_REQ);
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = OW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= OW'(NUM_REQ - 1);
            owner_q     <= '0;
            grant_q     <= '0;
            out_data_q  <= '0;
            out_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            tok_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            setup_cnt_q <= '0;
        end else begin
            grant_q <= '0;
            case (state_q)
                StIdle: begin
                    if (win_found) begin
                        out_data_q  <= bus.data[int'(win_idx)*BW_DATA +: BW_DATA];
                        grant_q     <= NUM_REQ'(1) << win_idx;
                        owner_q     <= win_idx;
                        ptr_q       <= win_idx;
                        setup_cnt_q <= SW'(SETUP_CYC - 1);
                        busy_q      <= 1'b1;
                        state_q     <= StSetup;
                    end
                end
                StSetup: begin
                    if (setup_cnt_q == '0) begin
                        out_req_q  <= ~out_req_q;
                        wait_cnt_q <= '0;
                        state_q    <= StWait;
                    end else begin
                        setup_cnt_q <= setup_cnt_q - 1'b1;
                    end
                end
                StWait: begin
                    if (ack_s == out_req_q) begin
                        tok_cnt_q <= tok_cnt_q + 16'd1;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        // Counter parks at TIMEOUT; the flag is sticky until reset.
                        if (wait_cnt_q != 16'(TIMEOUT)) begin
                            wait_cnt_q <= wait_cnt_q + 16'd1;
                        end
                        if (wait_cnt_q == 16'(TIMEOUT - 1)) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.owner    = owner_q;
    assign bus.out_data = out_data_q;
    assign bus.out_req  = out_req_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = timeout_q;
    assign bus.tok_cnt  = tok_cnt_q;
endmodule

// File: doc/src_sched_2ph.md
# src_sched_2ph

Clocked scheduler that shares one 2-phase bundled-data pipeline source among NUM_REQ synchronous requesters. It arbitrates round-robin, captures the winner's word onto the bundled data bus, and holds it for SETUP_CYC cycles to meet the bundling constraint. It then toggles the request wire and waits for the matching ack transition from the asynchronous pipeline. It sits at the clocked/asynchronous boundary, ahead of the first click stage.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- BW_DATA, 8, data word width
- SETUP_CYC, 2, cycles between data capture and request toggle (≥1)
- TIMEOUT, 255, WAIT cycles before o_timeout sets (≥1, fits 16 bits)

Ports:
- i_clk  in  1  single clock; all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_req  in  NUM_REQ  per-requester word-valid, level
- i_data  in  NUM_REQ*BW_DATA  requester k's word at bits [k*BW_DATA +: BW_DATA]
- o_grant  out  NUM_REQ  one-hot, one-cycle pulse; requester k's word consumed
- o_owner  out  clog2(NUM_REQ)  index of last granted requester
- o_out_data  out  BW_DATA  bundled data to pipeline
- o_out_req  out  1  2-phase request (toggles once per token)
- i_out_ack  in  1  2-phase ack from pipeline, asynchronous to i_clk
- o_busy  out  1  high in SETUP and WAIT
- o_timeout  out  1  sticky ack-timeout flag
- o_tok_cnt  out  16  completed handshakes, wraps modulo 2^16

## Operation
- Ack sync: i_out_ack passes through 2 flops into ack_s. Both flops reset to 0. No other logic samples i_out_ack.
- States: IDLE, SETUP, WAIT.
- IDLE, any i_req set: pick the first set bit in order ptr+1, ptr+2, … wrapping modulo NUM_REQ.
  - On that edge, capture the winner's word into o_out_data.
  - Pulse o_grant[winner] for one cycle.
  - Set o_owner and ptr to the winner.
  - Load the setup counter and go to SETUP.
- IDLE, no i_req: hold; no grant.
- SETUP: count SETUP_CYC cycles. On the final edge, toggle o_out_req, clear the wait counter, and go to WAIT.
- WAIT:
  - Handshake completes when ack_s == o_out_req.
  - On that edge: increment o_tok_cnt (0xFFFF→0x0000) and go to IDLE.
  - Otherwise the wait counter increments, saturating. When it reaches TIMEOUT, o_timeout sets.
  - After a timeout the block stays in WAIT. A late ack still completes normally.
- o_timeout clears only on reset.
- o_out_data and o_out_req never change in WAIT or SETUP, except the single req toggle.
- i_req/i_data changes outside IDLE are ignored. A requester holds i_req and its word until it sees its grant.
- Simultaneous requests: exactly one grant per token. The winner becomes lowest priority next round.

## Timing
- Reset values:
  - State IDLE; ptr = NUM_REQ-1, so requester 0 wins first.
  - o_grant 0, o_owner 0, o_out_data 0, o_out_req 0, o_busy 0, o_timeout 0, o_tok_cnt 0.
  - Both sync flops 0.
- Edge E0: request seen in IDLE. Data captured; o_grant high during cycle E0..E0+1; o_busy rises.
- o_out_req toggles at edge E0+SETUP_CYC, so data is stable ≥ SETUP_CYC cycles before the req edge.
- Ack toggling between edges Ea-1 and Ea: ack_s updates at Ea+1. Completion (to IDLE, o_tok_cnt+1, o_busy low) occurs at edge Ea+2.
- The next capture is no earlier than the edge after completion, so there is one IDLE cycle minimum. Minimum token period is SETUP_CYC+4 cycles with an immediate ack.
- o_timeout sets on the edge where the WAIT cycle count equals TIMEOUT.
- Reset mid-handshake forces o_out_req to 0 and abandons the token (no count). The pipeline must be reset concurrently to keep phase parity.

## Test plan
- Reset, then i_req=4'b0001, data0=0xA5; ack echoes req after 3 cycles. Required:
  - o_grant=0001 at E0; o_out_data=0xA5; o_out_req 0→1 at E0+2.
  - Completion at ack+2; o_tok_cnt=1.
- i_req=4'b1111 held, ack echoed promptly for 8 tokens: grant order 0,1,2,3,0,1,2,3; o_tok_cnt=8; never two grant bits set.
- After owner=1, i_req=4'b0011: grant goes to 0 (ptr+1 wraps past 2,3 to 0), then 1 next round.
- TIMEOUT=10, ack withheld: o_timeout rises 10 cycles after entering WAIT and stays WAIT. The ack then arrives: completion, o_tok_cnt+1, o_timeout remains 1.
- Assert i_rst during WAIT with o_out_req=1: all outputs return to reset values asynchronously; after release, first grant goes to the lowest-index requester.
- Preload o_tok_cnt path by running 65536 tokens (or force): next completion wraps to 0x0000.
